// File: rtl/tape_pulse_gen.sv
// Standard-speed Spectrum tape block transmitter: byte stream in, ROM-loader EAR pulse train out.
// Define TAPE_PAUSE_EN to add a tape_pause input that freezes timing and ear like ce=0.
module tape_pulse_gen #(
    parameter int unsigned PILOT_T     = 2168,
    parameter int unsigned PILOT_HDR_N = 8063,
    parameter int unsigned PILOT_DAT_N = 3223,
    parameter int unsigned SYNC1_T     = 667,
    parameter int unsigned SYNC2_T     = 735,
    parameter int unsigned BIT0_T      = 855,
    parameter int unsigned BIT1_T      = 1710,
    parameter int unsigned PAUSE_T     = 3500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
`ifdef TAPE_PAUSE_EN
    input  logic       tape_pause,
`endif
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       ear,
    output logic       busy,
    output logic       block_done,
    output logic       underrun
);
    localparam int unsigned CntW   = 22;
    localparam int unsigned PilotW = 14;

    typedef enum logic [2:0] {StIdle, StPilot, StSync1, StSync2, StData, StPause} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [PilotW-1:0] pilot_left_q;
    logic [7:0]        hold_data_q;
    logic              hold_last_q;
    logic              hold_full_q;
    logic [7:0]        shift_q;
    logic [2:0]        bit_q;
    logic              half_q;
    logic              last_q;
    logic              ear_q;
    logic              block_done_q;
    logic              underrun_q;
    logic              tick;

`ifdef TAPE_PAUSE_EN
    assign tick = ce & ~tape_pause;
`else
    assign tick = ce;
`endif

    function automatic logic [CntW-1:0] bit_len(input logic b);
        return b ? CntW'(BIT1_T) : CntW'(BIT0_T);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            pilot_left_q <= '0;
            hold_data_q  <= '0;
            hold_last_q  <= 1'b0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            bit_q        <= '0;
            half_q       <= 1'b0;
            last_q       <= 1'b0;
            ear_q        <= 1'b0;
            block_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            block_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            // The hold is only freed while full, so accept and free never collide
            if (s_valid && !hold_full_q) begin
                hold_data_q <= s_data;
                hold_last_q <= s_last;
                hold_full_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (hold_full_q) begin
                        state_q      <= StPilot;
                        cnt_q        <= CntW'(PILOT_T);
                        pilot_left_q <= hold_data_q[7] ? PilotW'(PILOT_DAT_N)
                                                       : PilotW'(PILOT_HDR_N);
                    end
                end
                StPilot: begin
                    if (tick) begin
                        if (cnt_q != CntW'(1)) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            ear_q <= ~ear_q;
                            if (pilot_left_q == PilotW'(1)) begin
                                state_q <= StSync1;
                                cnt_q   <= CntW'(SYNC1_T);
                            end else begin
                                pilot_left_q <= pilot_left_q - 1'b1;
                                cnt_q        <= CntW'(PILOT_T);
                            end
                        end
                    end
                end
                StSync1: begin
                    if (tick) begin
                        if (cnt_q != CntW'(1)) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            ear_q   <= ~ear_q;
                            state_q <= StSync2;
                            cnt_q   <= CntW'(SYNC2_T);
                        end
                    end
                end
                StSync2: begin
                    if (tick) begin
                        if (cnt_q != CntW'(1)) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            // Flag byte has sat in the hold since IDLE
                            ear_q       <= ~ear_q;
                            state_q     <= StData;
                            shift_q     <= hold_data_q;
                            last_q      <= hold_last_q;
                            hold_full_q <= 1'b0;
                            bit_q       <= '0;
                            half_q      <= 1'b0;
                            cnt_q       <= bit_len(hold_data_q[7]);
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        if (cnt_q != CntW'(1)) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else if (!half_q) begin
                            ear_q  <= ~ear_q;
                            half_q <= 1'b1;
                            cnt_q  <= bit_len(shift_q[7]);
                        end else if (bit_q != 3'd7) begin
                            ear_q   <= ~ear_q;
                            half_q  <= 1'b0;
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= {shift_q[6:0], 1'b0};
                            cnt_q   <= bit_len(shift_q[6]);
                        end else if (!last_q && hold_full_q) begin
                            ear_q       <= ~ear_q;
                            half_q      <= 1'b0;
                            shift_q     <= hold_data_q;
                            last_q      <= hold_last_q;
                            hold_full_q <= 1'b0;
                            bit_q       <= '0;
                            cnt_q       <= bit_len(hold_data_q[7]);
                        end else begin
                            half_q     <= 1'b0;
                            ear_q      <= 1'b0;
                            underrun_q <= ~last_q;
                            state_q    <= StPause;
                            cnt_q      <= CntW'(PAUSE_T);
                        end
                    end
                end
                StPause: begin
                    if (tick) begin
                        if (cnt_q != CntW'(1)) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            block_done_q <= 1'b1;
                            state_q      <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign s_ready    = ~hold_full_q;
    assign ear        = ear_q;
    assign busy       = (state_q != StIdle);
    assign block_done = block_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_tape_pulse_gen.sv
// Bench for tape_pulse_gen: queue-based half-pulse model checked every cycle, plus literal
// interval and pilot-count expectations on a second instance with the real pilot counts.
module tb_tape_pulse_gen;
    localparam int P_PT    = 3;
    localparam int P_HDR   = 9;
    localparam int P_DAT   = 5;
    localparam int P_S1    = 4;
    localparam int P_S2    = 5;
    localparam int P_B0    = 2;
    localparam int P_B1    = 6;
    localparam int P_PAUSE = 11;

    logic       clk;
    logic       reset;
    logic       ce;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       ear;
    logic       busy;
    logic       block_done;
    logic       underrun;
`ifdef TAPE_PAUSE_EN
    logic       tape_pause;
`endif

    logic       n_reset;
    logic [7:0] n_s_data;
    logic       n_s_valid;
    logic       n_s_last;
    logic       n_s_ready;
    logic       n_ear;
    logic       n_busy;
    logic       n_block_done;
    logic       n_underrun;

    int n_vec = 0;
    int n_err = 0;
    int ce_mode = 0;

    tape_pulse_gen #(
        .PILOT_T(P_PT), .PILOT_HDR_N(P_HDR), .PILOT_DAT_N(P_DAT), .SYNC1_T(P_S1),
        .SYNC2_T(P_S2), .BIT0_T(P_B0), .BIT1_T(P_B1), .PAUSE_T(P_PAUSE)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce),
`ifdef TAPE_PAUSE_EN
        .tape_pause(tape_pause),
`endif
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .ear(ear), .busy(busy), .block_done(block_done), .underrun(underrun)
    );

    // Real pilot counts, short everything else
    tape_pulse_gen #(
        .PILOT_T(4), .SYNC1_T(5), .SYNC2_T(6), .BIT0_T(2), .BIT1_T(3), .PAUSE_T(10)
    ) dut_n (
        .clk(clk), .reset(n_reset), .ce(1'b1),
`ifdef TAPE_PAUSE_EN
        .tape_pause(1'b0),
`endif
        .s_data(n_s_data), .s_valid(n_s_valid), .s_last(n_s_last), .s_ready(n_s_ready),
        .ear(n_ear), .busy(n_busy), .block_done(n_block_done), .underrun(n_underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model: pending half-pulse lengths in a queue
    int   q_len[$];
    int   m_rem = 0;
    int   m_phase = 0;  // 0 idle, 1 pilot+sync, 2 data, 3 pause
    bit   m_ear = 0, m_hold_full = 0, m_hold_last = 0, m_cur_last = 0;
    bit   m_done = 0, m_under = 0, model_live = 0;
    logic [7:0] m_hold_data = 8'h00;

    function automatic bit tp_eff();
`ifdef TAPE_PAUSE_EN
        return tape_pause;
`else
        return 1'b0;
`endif
    endfunction

    task automatic take_byte();
        m_cur_last = m_hold_last;
        for (int i = 7; i >= 0; i--) begin
            q_len.push_back(m_hold_data[i] ? P_B1 : P_B0);
            q_len.push_back(m_hold_data[i] ? P_B1 : P_B0);
        end
        m_hold_full = 0;
        m_rem = q_len.pop_front();
        m_phase = 2;
    endtask

    task automatic model_step();
        bit acc;
        bit tck;
        int n;
        acc = (s_valid === 1'b1) && !m_hold_full;
        tck = (ce === 1'b1) && !tp_eff();
        m_done = 0;
        m_under = 0;
        if (reset === 1'b1) begin
            q_len.delete();
            m_phase = 0; m_ear = 0; m_hold_full = 0; m_rem = 0;
        end else begin
            if (m_phase == 0) begin
                if (m_hold_full) begin
                    n = m_hold_data[7] ? P_DAT : P_HDR;
                    q_len.delete();
                    repeat (n) q_len.push_back(P_PT);
                    q_len.push_back(P_S1);
                    q_len.push_back(P_S2);
                    m_rem = q_len.pop_front();
                    m_phase = 1;
                end
            end else if (tck) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_phase == 3) begin
                        m_done = 1;
                        m_phase = 0;
                    end else if (q_len.size() > 0) begin
                        m_ear = !m_ear;
                        m_rem = q_len.pop_front();
                    end else if (m_hold_full && (m_phase == 1 || !m_cur_last)) begin
                        m_ear = !m_ear;
                        take_byte();
                    end else begin
                        m_under = !m_cur_last;
                        m_ear = 0;
                        m_phase = 3;
                        m_rem = P_PAUSE;
                    end
                end
            end
            if (acc) begin
                m_hold_full = 1;
                m_hold_data = s_data;
                m_hold_last = s_last;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            model_live = 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                check_bit("ear", ear, m_ear);
                check_bit("busy", busy, m_phase != 0);
                check_bit("s_ready", s_ready, !m_hold_full);
                check_bit("block_done", block_done, m_done);
                check_bit("underrun", underrun, m_under);
            end
        end
    end

    // ---------------- interval recorder: clk cycles between ear edges since busy rose
    int   iv[$];
    int   rc = 0, und_n = 0, done_n = 0, und_at = -1;
    logic busy_prev = 1'b0, ear_prev = 1'b0, done_busy = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && busy_prev !== 1'b1) begin
                iv.delete();
                rc = 0; und_n = 0; done_n = 0; und_at = -1;
            end else begin
                rc++;
                if (ear !== ear_prev) begin
                    iv.push_back(rc);
                    rc = 0;
                end
                if (underrun === 1'b1) begin
                    und_n++;
                    und_at = iv.size();
                end
                if (block_done === 1'b1) begin
                    done_n++;
                    done_busy = busy;
                    iv.push_back(rc);
                end
            end
            busy_prev = busy;
            ear_prev = ear;
        end
    end

    initial begin
        int ph = 0;
        ce = 1'b1;
`ifdef TAPE_PAUSE_EN
        tape_pause = 1'b0;
`endif
        forever begin
            @(negedge clk);
            ph++;
            case (ce_mode)
                1:       ce = ($urandom_range(0, 2) != 0);
                2:       ce = (ph % 4 == 0);
                default: ce = 1'b1;
            endcase
`ifdef TAPE_PAUSE_EN
            tape_pause = (ce_mode == 1) && ($urandom_range(0, 7) == 0);
`endif
        end
    end

    // ---------------- expected interval lists built straight from the pulse rules
    int exp_q[$];

    task automatic exp_start(input logic [7:0] flag);
        exp_q.delete();
        repeat (flag[7] ? P_DAT : P_HDR) exp_q.push_back(P_PT);
        exp_q.push_back(P_S1);
        exp_q.push_back(P_S2);
    endtask

    task automatic exp_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back(b[i] ? P_B1 : P_B0);
            exp_q.push_back(b[i] ? P_B1 : P_B0);
        end
    endtask

    // Last half-pulse ends at ear=0 already, so it merges with the pause
    task automatic exp_end();
        int l;
        l = exp_q.pop_back();
        exp_q.push_back(l + P_PAUSE);
    endtask

    task automatic cmp_iv(input string name, input int scale, input int first);
        check_int({name, "_len"}, iv.size(), exp_q.size());
        for (int k = first; k < iv.size() && k < exp_q.size(); k++)
            check_int({name, "_iv"}, iv[k], exp_q[k] * scale);
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        bit ok = 0;
        s_data = d; s_last = l; s_valid = 1'b1;
        for (int w = 0; w < 5000; w++) begin
            if (s_ready === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        check_int("push_accept", ok, 1);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int g = 0; g < 20000; g++) begin
            @(negedge clk);
            if (busy === 1'b0 && s_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        check_int({name, "_idle"}, ok, 1);
    endtask

    task automatic n_block(input logic [7:0] flag, input int exp_n, input string name);
        int cnt = 0, run = 0, dn = 0, un = 0, g = 0;
        logic prev;
        check_bit({name, "_ready"}, n_s_ready, 1'b1);
        n_s_data = flag; n_s_last = 1'b1; n_s_valid = 1'b1;
        @(negedge clk);
        n_s_valid = 1'b0;
        while (n_busy !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        prev = n_ear;
        for (int k = 0; k < 40000; k++) begin
            @(negedge clk);
            run++;
            if (n_ear !== prev) begin
                prev = n_ear;
                if (run == 4) begin
                    cnt++;
                    run = 0;
                end else begin
                    break;
                end
            end
        end
        check_int({name, "_pilot_n"}, cnt, exp_n);
        check_int({name, "_sync1_len"}, run, 5);
        for (int k = 0; k < 2000 && n_busy === 1'b1; k++) begin
            @(negedge clk);
            if (n_block_done === 1'b1) dn++;
            if (n_underrun === 1'b1) un++;
        end
        check_int({name, "_done"}, dn, 1);
        check_int({name, "_underrun"}, un, 0);
    endtask

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog t=%0t got timeout expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        n_reset = 1'b1; n_s_valid = 1'b0; n_s_data = 8'h00; n_s_last = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_reset = 1'b0;
        fork
            begin
                check_bit("rst_ready", s_ready, 1'b1);
                check_bit("rst_ear", ear, 1'b0);
                check_bit("rst_busy", busy, 1'b0);

                // Header block: flag 0x00 then 0xAA (last)
                push(8'h00, 1'b0);
                push(8'hAA, 1'b1);
                wait_idle("hdr");
                exp_start(8'h00); exp_byte(8'h00); exp_byte(8'hAA); exp_end();
                cmp_iv("hdr", 1, 0);
                check_int("hdr_first_edge", iv[0], 3);
                check_int("hdr_sync1", iv[P_HDR], 4);
                check_int("hdr_tail", iv[iv.size() - 1], 13);
                check_int("hdr_underrun", und_n, 0);
                check_int("hdr_done_n", done_n, 1);
                check_bit("hdr_done_busy", done_busy, 1'b0);

                // Underrun: data flag without last, nothing follows
                push(8'hFF, 1'b0);
                wait_idle("und");
                exp_start(8'hFF); exp_byte(8'hFF); exp_end();
                cmp_iv("und", 1, 0);
                check_int("und_n", und_n, 1);
                check_int("und_pos", und_at, P_DAT + 2 + 15);
                check_int("und_done_n", done_n, 1);

                // Backpressure: three bytes back to back
                push(8'h12, 1'b0);
                check_bit("bp_ready_low", s_ready, 1'b0);
                push(8'h34, 1'b0);
                push(8'hC5, 1'b1);
                wait_idle("bp");
                exp_start(8'h12); exp_byte(8'h12); exp_byte(8'h34); exp_byte(8'hC5);
                exp_end();
                cmp_iv("bp", 1, 0);

                // ce one cycle in four: every interval after the first scales by 4
                ce_mode = 2;
                push(8'h00, 1'b0);
                push(8'hAA, 1'b1);
                wait_idle("ce4");
                exp_start(8'h00); exp_byte(8'h00); exp_byte(8'hAA); exp_end();
                cmp_iv("ce4", 4, 1);
                check_int("ce4_first", (iv[0] >= 9 && iv[0] <= 12) ? 1 : 0, 1);
                ce_mode = 0;

                // Reset during DATA, then a fresh block gets a full pilot
                push(8'h00, 1'b0);
                push(8'h55, 1'b1);
                for (int g = 0; g < 2000 && iv.size() < P_HDR + 5; g++) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                check_bit("rstmid_ear", ear, 1'b0);
                check_bit("rstmid_busy", busy, 1'b0);
                check_bit("rstmid_ready", s_ready, 1'b1);
                reset = 1'b0;
                push(8'h80, 1'b1);
                wait_idle("rst2");
                exp_start(8'h80); exp_byte(8'h80); exp_end();
                cmp_iv("rst2", 1, 0);

                // Random stream: random bytes, lasts, gaps and ce density
                ce_mode = 1;
                for (int i = 0; i < 40; i++) begin
                    repeat (($urandom_range(0, 3) == 0) ? $urandom_range(20, 120)
                                                        : $urandom_range(0, 4)) @(negedge clk);
                    push(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
                    if (i % 10 == 9) ce_mode = $urandom_range(0, 2);
                end
                wait_idle("rnd");
                ce_mode = 0;
            end
            begin
                n_block(8'hFF, 3223, "dat_cnt");
                repeat (3) @(negedge clk);
                n_block(8'h00, 8063, "hdr_cnt");
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
